// File: rtl/sys_bus_fabric.sv
// rtl/sys_bus_fabric.sv - registered mask-decoded CPU-to-slave bus fabric
// Wait states, slave-ready handshake, watchdog and bus-error response per region.
module sys_bus_fabric #(
  parameter int                   ADDR_W      = 13,
  parameter int                   DATA_W      = 8,
  parameter int                   NREG        = 2,
  parameter logic [NREG*ADDR_W-1:0] REGION_BASE = {13'h1800, 13'h0000},
  parameter logic [NREG*ADDR_W-1:0] REGION_MASK = {13'h1800, 13'h1800},
  parameter logic [NREG*4-1:0]      REGION_WAIT = {4'd0, 4'd1},
  parameter int                   TIMEOUT     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_wr,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ack,
  output logic                   cpu_err,
  output logic [NREG-1:0]        sl_sel,
  output logic                   sl_rd,
  output logic                   sl_wr,
  output logic [ADDR_W-1:0]      sl_addr,
  output logic [DATA_W-1:0]      sl_wdata,
  input  logic [NREG*DATA_W-1:0] sl_rdata,
  input  logic [NREG-1:0]        sl_ready,
  output logic [7:0]             err_count
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t              r_state, w_state_n;
  logic [IDX_W-1:0]    r_idx, w_idx_n;
  logic                r_wr, w_wr_n;
  logic [3:0]          r_wait, w_wait_n;
  logic [WD_W-1:0]     r_wd, w_wd_n, w_wd_inc;
  logic [ADDR_W-1:0]   r_sl_addr, w_addr_n;
  logic [DATA_W-1:0]   r_sl_wdata, w_wdata_n;
  logic [DATA_W-1:0]   r_rdata, w_rdata_n;
  logic [7:0]          r_err_count, w_cnt_n, w_cnt_sat;
  logic [NREG-1:0]     r_sl_sel, w_sel_n;
  logic                r_sl_rd, r_sl_wr, r_ack, r_err;
  logic                w_rd_n, w_slwr_n, w_ack_n, w_err_n;
  logic                w_hit;
  logic [IDX_W-1:0]    w_hit_idx;

  // Descending scan so the lowest-index matching region wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((cpu_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
          (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W])) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_wd_inc  = r_wd + 1'b1;
  assign w_cnt_sat = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_wr_n    = r_wr;
    w_wait_n  = r_wait;
    w_wd_n    = r_wd;
    w_addr_n  = r_sl_addr;
    w_wdata_n = r_sl_wdata;
    w_rdata_n = r_rdata;
    w_cnt_n   = r_err_count;
    case (r_state)
      IDLE: begin
        if (cpu_req) begin
          w_addr_n  = cpu_addr;
          w_wdata_n = cpu_wdata;
          w_wr_n    = cpu_wr;
          if (w_hit) begin
            w_state_n = ACCESS;
            w_idx_n   = w_hit_idx;
            w_wait_n  = REGION_WAIT[w_hit_idx*4 +: 4];
            w_wd_n    = '0;
          end else begin
            w_state_n = ERR;
            w_rdata_n = '0;
            w_cnt_n   = w_cnt_sat;
          end
        end
      end
      ACCESS: begin
        w_wd_n = w_wd_inc;
        // Watchdog expiry beats a same-cycle ready.
        if ((TIMEOUT != 0) && (w_wd_inc == WD_W'(TIMEOUT))) begin
          w_state_n = ERR;
          w_rdata_n = '0;
          w_cnt_n   = w_cnt_sat;
        end else if (r_wait != 4'd0) begin
          w_wait_n = r_wait - 4'd1;
        end else if (sl_ready[r_idx]) begin
          w_state_n = DONE;
          if (!r_wr) w_rdata_n = sl_rdata[r_idx*DATA_W +: DATA_W];
        end
      end
      DONE:    w_state_n = IDLE;
      ERR:     w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Output values are computed from the next state so every output comes straight from a flop.
  always_comb begin
    w_ack_n  = (w_state_n == DONE) || (w_state_n == ERR);
    w_err_n  = (w_state_n == ERR);
    w_sel_n  = (w_state_n == ACCESS) ? (NREG'(1) << w_idx_n) : '0;
    w_rd_n   = (w_state_n == ACCESS) && !w_wr_n;
    w_slwr_n = (w_state_n == ACCESS) && w_wr_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_wr        <= 1'b0;
      r_wait      <= '0;
      r_wd        <= '0;
      r_sl_addr   <= '0;
      r_sl_wdata  <= '0;
      r_rdata     <= '0;
      r_err_count <= '0;
      r_sl_sel    <= '0;
      r_sl_rd     <= 1'b0;
      r_sl_wr     <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_wr        <= w_wr_n;
      r_wait      <= w_wait_n;
      r_wd        <= w_wd_n;
      r_sl_addr   <= w_addr_n;
      r_sl_wdata  <= w_wdata_n;
      r_rdata     <= w_rdata_n;
      r_err_count <= w_cnt_n;
      r_sl_sel    <= w_sel_n;
      r_sl_rd     <= w_rd_n;
      r_sl_wr     <= w_slwr_n;
      r_ack       <= w_ack_n;
      r_err       <= w_err_n;
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_ack   = r_ack;
  assign cpu_err   = r_err;
  assign sl_sel    = r_sl_sel;
  assign sl_rd     = r_sl_rd;
  assign sl_wr     = r_sl_wr;
  assign sl_addr   = r_sl_addr;
  assign sl_wdata  = r_sl_wdata;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_sys_bus_fabric.sv
// tb/tb_sys_bus_fabric.sv - scoreboard bench for sys_bus_fabric
// Second instance uses an overlapping catch-all region 1 to check priority decode.
module tb_sys_bus_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [15:0] sl_rdata;
  logic [1:0]  sl_ready;

  logic [7:0]  cpu_rdata, err_count, ov_rdata, ov_err_count;
  logic        cpu_ack, cpu_err, sl_rd, sl_wr, ov_ack, ov_err, ov_rd, ov_wr;
  logic [1:0]  sl_sel, ov_sel;
  logic [12:0] sl_addr, ov_addr;
  logic [7:0]  sl_wdata, ov_wdata;

  always #5 clk = ~clk;

  sys_bus_fabric dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .sl_sel(sl_sel), .sl_rd(sl_rd), .sl_wr(sl_wr), .sl_addr(sl_addr), .sl_wdata(sl_wdata),
    .sl_rdata(sl_rdata), .sl_ready(sl_ready), .err_count(err_count)
  );

  sys_bus_fabric #(
    .REGION_BASE({13'h0000, 13'h0000}),
    .REGION_MASK({13'h0000, 13'h1800})
  ) dut_ov (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(ov_rdata), .cpu_ack(ov_ack), .cpu_err(ov_err),
    .sl_sel(ov_sel), .sl_rd(ov_rd), .sl_wr(ov_wr), .sl_addr(ov_addr), .sl_wdata(ov_wdata),
    .sl_rdata(sl_rdata), .sl_ready(sl_ready), .err_count(ov_err_count)
  );

  typedef struct {
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [7:0]  last_rd = 8'h00;
  logic [1:0]  ov_sel_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every completion pulse pops one expected response.
  always @(negedge clk) begin
    if (!rst && cpu_err && !cpu_ack) check("err_without_ack", 1, 0);
    if (!rst && cpu_ack) begin
      if (sb_q.size() == 0) begin
        check("spurious_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_err", cpu_err, e.err);
        check("ack_rdata", cpu_rdata, e.rdata);
      end
    end
  end

  task automatic do_xfer(input logic wr, input logic [12:0] addr, input logic [7:0] wdata,
                         input logic exp_err, input logic [1:0] exp_sel,
                         input int exp_acc, input int stall);
    int   acc;
    int   total;
    logic got_ack;
    exp_t e;
    acc = 0; total = 0; got_ack = 1'b0;
    if (exp_err) last_rd = 8'h00;
    else if (!wr) last_rd = (exp_sel == 2'b01) ? sl_rdata[7:0] : sl_rdata[15:8];
    e.err = exp_err; e.rdata = last_rd;
    sb_q.push_back(e);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    sl_ready = (stall == 0) ? 2'b11 : 2'b00;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      total++;
      if (cpu_ack) begin
        got_ack = 1'b1;
        break;
      end
      if (sl_sel != 2'b00) begin
        acc++;
        check("sl_sel", sl_sel, exp_sel);
        check("sl_rd", sl_rd, !wr);
        check("sl_wr", sl_wr, wr);
        if (acc == 1) begin
          ov_sel_first = ov_sel;
          check("sl_addr", sl_addr, addr);
          if (wr) check("sl_wdata", sl_wdata, wdata);
        end
        sl_ready = (acc > stall) ? 2'b11 : 2'b00;
      end
    end
    check("ack_seen", got_ack, 1);
    check("access_cycles", acc, exp_acc);
    check("latency", total, exp_acc + 1);
    cpu_req = 1'b0;
    sl_ready = 2'b11;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit got;
    rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    sl_rdata = {8'h5A, 8'hA5}; sl_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", cpu_ack, 0);
    check("rst_sel", sl_sel, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_addr", sl_addr, 0);
    check("rst_errcnt", err_count, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    do_xfer(1'b0, 13'h0123, 8'h00, 1'b0, 2'b01, 2, 0);    // ROM read, W=1
    do_xfer(1'b1, 13'h1805, 8'h3C, 1'b0, 2'b10, 1, 0);    // RAM write, W=0
    check("write_keeps_rdata", cpu_rdata, 8'hA5);
    do_xfer(1'b0, 13'h0010, 8'h00, 1'b0, 2'b01, 2, 0);    // overlap priority
    check("ovl_sel", ov_sel_first, 2'b01);
    do_xfer(1'b0, 13'h1ABC, 8'h00, 1'b0, 2'b10, 1, 0);    // RAM read
    do_xfer(1'b0, 13'h0900, 8'h00, 1'b1, 2'b00, 0, 0);    // unmapped
    check("errcnt_1", err_count, 1);
    do_xfer(1'b0, 13'h1801, 8'h00, 1'b0, 2'b10, 4, 3);    // stall 3 cycles
    do_xfer(1'b0, 13'h1802, 8'h00, 1'b1, 2'b10, 8, 255);  // watchdog
    check("errcnt_2", err_count, 2);
    do_xfer(1'b0, 13'h0124, 8'h00, 1'b1, 2'b01, 8, 255);  // watchdog with wait states
    for (int k = 0; k < 300; k++)
      do_xfer(k[0], 13'h0800 | 13'(k), 8'(k), 1'b1, 2'b00, 0, 0);
    check("errcnt_sat", err_count, 255);

    // Reset while a ROM read is stalled in ACCESS; request held through reset.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h0123; sl_ready = 2'b00;
    @(posedge clk); #1;
    check("pre_rst_sel", sl_sel, 2'b01);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_sel", sl_sel, 0);
    check("async_rd", sl_rd, 0);
    check("async_ack", cpu_ack, 0);
    check("async_errcnt", err_count, 0);
    check("async_rdata", cpu_rdata, 0);
    @(negedge clk) rst = 1'b0;
    sl_ready = 2'b11;
    begin
      exp_t e;
      e.err = 1'b0; e.rdata = 8'hA5;
      sb_q.push_back(e);
    end
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin got = 1; break; end
    end
    check("restart_ack", got, 1);
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
